// File: rtl/regfile_sb.sv
// Multi-port register file with a busy scoreboard: 2 write, 3 read, 1 reserve port.
// Read data and busy flags are registered (1-cycle latency); no flow control, every port is accepted every cycle.
module regfile_sb #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 16,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [$clog2(DEPTH)-1:0] waddr0,
  input  logic [$clog2(DEPTH)-1:0] waddr1,
  input  logic [WIDTH-1:0]         wdata0,
  input  logic [WIDTH-1:0]         wdata1,
  input  logic                     rsv_en,
  input  logic [$clog2(DEPTH)-1:0] rsv_addr,
  input  logic [$clog2(DEPTH)-1:0] raddr0,
  input  logic [$clog2(DEPTH)-1:0] raddr1,
  input  logic [$clog2(DEPTH)-1:0] raddr2,
  output logic [WIDTH-1:0]         rdata0,
  output logic [WIDTH-1:0]         rdata1,
  output logic [WIDTH-1:0]         rdata2,
  output logic                     rbusy0,
  output logic                     rbusy1,
  output logic                     rbusy2,
  output logic [DEPTH-1:0]         busy_vec
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] mem_nxt [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  logic wr0_ok;
  logic wr1_ok;
  logic rsv_ok;

  // A hardwired r0 swallows every write and reservation aimed at it.
  assign wr0_ok = we0    && !((ZERO_R0 != 0) && (waddr0   == '0));
  assign wr1_ok = we1    && !((ZERO_R0 != 0) && (waddr1   == '0));
  assign rsv_ok = rsv_en && !((ZERO_R0 != 0) && (rsv_addr == '0));

  // Port 1 is applied after port 0 so it wins on a collision; a reservation
  // is applied last so it wins over a same-edge write-back.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_nxt[i]  = mem[i];
      busy_nxt[i] = busy[i];
      if (wr0_ok && (waddr0 == AW'(i))) begin
        mem_nxt[i]  = wdata0;
        busy_nxt[i] = 1'b0;
      end
      if (wr1_ok && (waddr1 == AW'(i))) begin
        mem_nxt[i]  = wdata1;
        busy_nxt[i] = 1'b0;
      end
      if (rsv_ok && (rsv_addr == AW'(i))) begin
        busy_nxt[i] = 1'b1;
      end
    end
  end

  logic [AW-1:0]    raddr  [3];
  logic [WIDTH-1:0] rd_src [3];
  logic             rb_src [3];

  assign raddr[0] = raddr0;
  assign raddr[1] = raddr1;
  assign raddr[2] = raddr2;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd_src[p] = (BYPASS != 0) ? mem_nxt[raddr[p]]  : mem[raddr[p]];
      rb_src[p] = (BYPASS != 0) ? busy_nxt[raddr[p]] : busy[raddr[p]];
      if ((ZERO_R0 != 0) && (raddr[p] == '0)) begin
        rd_src[p] = '0;
        rb_src[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy   <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
      rdata2 <= '0;
      rbusy0 <= 1'b0;
      rbusy1 <= 1'b0;
      rbusy2 <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= mem_nxt[i];
      end
      busy   <= busy_nxt;
      rdata0 <= rd_src[0];
      rdata1 <= rd_src[1];
      rdata2 <= rd_src[2];
      rbusy0 <= rb_src[0];
      rbusy1 <= rb_src[1];
      rbusy2 <= rb_src[2];
    end
  end

  assign busy_vec = busy;

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 16, register count; power of two, 4..64; AW = log2(DEPTH).
REQ-003 SHALL have parameter BYPASS, default 1; 1 = same-cycle write data forwarded to reads, 0 = reads return pre-write contents.
REQ-004 SHALL have parameter ZERO_R0, default 0; 1 = register 0 reads as 0, ignores writes, and is never busy.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- we0 / we1  in  1  write enables, ports 0/1
- waddr0 / waddr1  in  AW  write addresses
- wdata0 / wdata1  in  WIDTH  write data
- rsv_en  in  1  reserve request: mark rsv_addr busy
- rsv_addr  in  AW  register to reserve
- raddr0 / raddr1 / raddr2  in  AW  read addresses
- rdata0 / rdata1 / rdata2  out  WIDTH  registered read data
- rbusy0 / rbusy1 / rbusy2  out  1  registered busy flag of the register read
- busy_vec  out  DEPTH  registered scoreboard, bit i = register i busy

Function
REQ-006 SHALL apply each enabled write to mem[waddr] on the rising edge of clk.
REQ-007 SHALL, when we0 and we1 target the same address in one cycle, store wdata1 only (port 1 priority).
REQ-008 SHALL perform independent writes to different addresses in the same cycle.
REQ-009 SHALL update rdataN and rbusyN one cycle after raddrN is presented (read latency 1).
REQ-010 SHALL, with BYPASS=1, load rdataN with the write data of the same edge when an enabled write targets raddrN (port 1 data if both ports match); with BYPASS=0, load the pre-write contents.
REQ-011 SHALL set busy_vec[rsv_addr] on the edge where rsv_en=1.
REQ-012 SHALL clear busy_vec[a] on any edge where an enabled write targets a and no reservation for a occurs on that edge.
REQ-013 SHALL keep the bit set when a reservation and a write target the same register on one edge (new reservation wins).
REQ-014 SHALL derive rbusyN by the same forwarding rule as REQ-010: next-state busy bit for BYPASS=1, current bit for BYPASS=0.
REQ-015 SHALL, with ZERO_R0=1, drop writes and reservations to address 0, keep busy_vec[0]=0, and return rdataN=0 and rbusyN=0 for raddrN=0.
REQ-016 SHALL allow all three read ports to address the same register simultaneously with identical results.
REQ-017 SHALL treat reserve of an already busy register as a no-op (bit stays 1) and writes to non-busy registers as normal writes.

Reset
REQ-018 SHALL, while rst_n=0, asynchronously force all registers, rdata0..2, rbusy0..2 and busy_vec to 0.
REQ-019 SHALL ignore all writes, reservations and reads while rst_n=0, and resume normal operation on the first rising edge after rst_n goes high.
REQ-020 SHALL discard a write or reservation in the cycle that reset asserts; the reset values take precedence.

Verification
REQ-021 Reset then read every address -> all rdata=0, rbusy=0, busy_vec=0.
REQ-022 Write port0 r3=0xA5A5A5A5 and port1 r7=0x12345678 on one edge, then read r3,r7,r3 -> rdata0=0xA5A5A5A5, rdata1=0x12345678, rdata2=0xA5A5A5A5.
REQ-023 Both ports write r5 (0x11111111 / 0x22222222) -> r5=0x22222222; with BYPASS=1, raddr0=5 on the same edge -> rdata0=0x22222222; with BYPASS=0 -> old value.
REQ-024 rsv r9, then write r9 -> busy_vec[9]: 1 then 0; rsv and write r9 on one edge -> busy_vec[9]=1; rbusy0 follows for raddr0=9.
REQ-025 ZERO_R0=1: write 0xFFFFFFFF and reserve r0 -> rdata=0, busy_vec[0]=0.
REQ-026 Drop rst_n mid-stream with r2 busy and r2=0xDEADBEEF -> outputs 0 immediately without a clock edge; after release, read r2 -> 0, not busy.
